// File: rtl/fetch_pc_unit.sv
// Program-counter and instruction-fetch stage.
//
// Holds the PC, drives the instruction-memory address and registers {instr, pc}
// into the IF/ID register, which is offered to decode with a valid/ready
// handshake. Handles stall, jump redirect (with flush), start and halt.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             one-cycle pulse: begin fetching at RESET_PC (IDLE/HALT only)
//   redirect_valid    taken jump this cycle; redirect_target is the new PC
//   stall             hazard stall from decode/execute
//   imem_addr         instruction-memory address (= pc), imem_rdata read same cycle
//   if_valid/if_ready IF/ID handshake; if_instr/if_pc are the registered payload
//   done              HALT word fetched
//   redirect_cnt      accepted redirects        (FETCH_PC_STATS_EN only, else 0)
//   fetch_cnt         IF/ID handshakes          (FETCH_PC_STATS_EN only, else 0)
//
// Build option: define FETCH_PC_STATS_EN to build the saturating statistics
// counters; without it both counter outputs are tied to zero.
module fetch_pc_unit #(
  parameter int unsigned          PC_W       = 16,
  parameter int unsigned          INSTR_W    = 9,
  parameter logic [PC_W-1:0]      RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic               stall,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               done,
  output logic [15:0]        redirect_cnt,
  output logic [15:0]        fetch_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               done_q, done_d;

  logic advance;
  logic handshake;

  // IF/ID may be overwritten when empty, or when decode takes it this cycle.
  assign advance   = !if_valid_q || (if_ready && !stall);
  assign handshake = if_valid_q && if_ready && !stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    done_d     = done_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pc_d    = RESET_PC;
        end
      end
      StRun: begin
        if (redirect_valid) begin
          // Redirect beats stall and backpressure; the in-flight fetch is dropped.
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (advance) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (imem_rdata == HALT_INSTR) begin
            state_d = StHalt;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      StHalt: begin
        // Drain the halt word to decode; no further fetch.
        if (handshake) begin
          if_valid_d = 1'b0;
        end
        if (start) begin
          state_d = StRun;
          pc_d    = RESET_PC;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      done_q     <= done_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign done      = done_q;

`ifdef FETCH_PC_STATS_EN
  logic [15:0] redirect_cnt_q;
  logic [15:0] fetch_cnt_q;
  logic        start_accept;
  logic        redirect_accept;

  // start only takes effect outside RUN, so only then does it clear the stats.
  assign start_accept    = start && (state_q != StRun);
  assign redirect_accept = (state_q == StRun) && redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      fetch_cnt_q    <= '0;
    end else if (start_accept) begin
      redirect_cnt_q <= '0;
      fetch_cnt_q    <= '0;
    end else begin
      if (redirect_accept && (redirect_cnt_q != 16'hFFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
      if (handshake && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign fetch_cnt    = fetch_cnt_q;
`else
  assign redirect_cnt = 16'h0000;
  assign fetch_cnt    = 16'h0000;
`endif

endmodule
